// File: rtl/wishbone_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_pkg
// Description : Shared Wishbone types for the 64-bit command initiator:
//               request/response structs, CTI encodings, response decode
//               helper and the initiator completion status enum.
// Revision    : 1.0 - initial release
// ============================================================================
package wishbone_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 64;
  localparam int WB_SEL_W = 8;
  localparam int WB_TID_W = 4;

  typedef enum logic [2:0] {
    WB_CTI_CLASSIC = 3'b000,
    WB_CTI_ERC     = 3'b111
  } wb_cti_t;

  typedef struct packed {
    logic                cyc;
    logic                stb;
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_TID_W-1:0] tid;
    wb_cti_t             cti;
  } wb_cmd_request64_t;

  typedef struct packed {
    logic                ack;
    logic                err;
    logic                rty;
    logic [WB_TID_W-1:0] tid;
    logic [WB_DAT_W-1:0] dat;
  } wb_cmd_response64_t;

  typedef enum logic [1:0] {
    WB_RSP_NONE = 2'd0,
    WB_RSP_ACK  = 2'd1,
    WB_RSP_ERR  = 2'd2,
    WB_RSP_RTY  = 2'd3
  } wb_rsp_code_t;

  typedef enum logic [1:0] {
    INIT_OK         = 2'd0,
    INIT_ERR        = 2'd1,
    INIT_TIMEOUT    = 2'd2,
    INIT_RETRY_FAIL = 2'd3
  } wb_init_status_t;

  // Error outranks retry, retry outranks ack when a responder raises several.
  function automatic wb_rsp_code_t wb_rsp_decode(input wb_cmd_response64_t r);
    if (r.err)      return WB_RSP_ERR;
    else if (r.rty) return WB_RSP_RTY;
    else if (r.ack) return WB_RSP_ACK;
    else            return WB_RSP_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_cmd_initiator64.sv
`default_nettype none
// ============================================================================
// Module      : wb_cmd_initiator64
// Description : Single-outstanding Wishbone command initiator with
//               transaction IDs, retry with fixed back-off and optional
//               response timeout (enabled by macro WB_INIT_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_cmd_initiator64
  import wishbone_pkg::*;
#(
`ifdef WB_INIT_TIMEOUT_EN
  parameter int TIMEOUT   = 1023,
`endif
  parameter int MAX_RETRY = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic                cmd_posted,
  input  logic [31:0]         cmd_adr,
  input  logic [7:0]          cmd_sel,
  input  logic [63:0]         cmd_dat,
  output wb_cmd_request64_t   req,
  input  wb_cmd_response64_t  resp,
  output logic                rsp_valid,
  output logic [1:0]          rsp_status,
  output logic [63:0]         rsp_dat
);

  localparam logic [1:0] c_backoff_last = 2'd3;
  localparam logic [7:0] c_max_retry    = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_BACKOFF = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic                  r_posted;
  logic [31:0]           r_adr;
  logic [7:0]            r_sel;
  logic [63:0]           r_dat;
  logic [WB_TID_W-1:0]   r_tid;
  logic [7:0]            r_retry;
  logic [1:0]            r_backoff;
  logic [1:0]            r_rsp_status;
  logic [63:0]           r_rsp_dat;
  logic                  w_accept;
  logic                  w_match;
  logic                  w_bus_active;
  logic                  w_retry_inc;
  wb_rsp_code_t          w_code;
  wb_init_status_t       w_status;
  logic [63:0]           w_dat;

  assign w_accept     = (r_state == S_IDLE) && cmd_valid;
  assign w_code       = wb_rsp_decode(resp);
  assign w_match      = (resp.tid == r_tid) && (w_code != WB_RSP_NONE);
  assign w_bus_active = (r_state == S_ISSUE) || (r_state == S_WAIT);

`ifdef WB_INIT_TIMEOUT_EN
  localparam logic [9:0] c_tmo_last = 10'(TIMEOUT - 1);
  logic [9:0] r_tmo;
  logic       w_tmo_hit;

  // Counts WAIT cycles; zeroed during every ISSUE so each reissue gets a full window.
  always_ff @(posedge clk) begin
    if (rst)                     r_tmo <= '0;
    else if (r_state == S_ISSUE) r_tmo <= '0;
    else if (r_state == S_WAIT)  r_tmo <= r_tmo + 10'd1;
  end

  assign w_tmo_hit = (r_state == S_WAIT) && (r_tmo == c_tmo_last);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode plus the status/data to be presented on completion.
  always_comb begin
    w_next      = r_state;
    w_status    = INIT_OK;
    w_dat       = '0;
    w_retry_inc = 1'b0;
    case (r_state)
      S_IDLE:    if (cmd_valid) w_next = S_ISSUE;
      S_ISSUE:   w_next = (r_we && r_posted) ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (w_match) begin
          case (w_code)
            WB_RSP_ERR: begin
              w_next   = S_DONE;
              w_status = INIT_ERR;
            end
            WB_RSP_RTY: begin
              if (r_retry < c_max_retry) begin
                w_next      = S_BACKOFF;
                w_retry_inc = 1'b1;
              end else begin
                w_next   = S_DONE;
                w_status = INIT_RETRY_FAIL;
              end
            end
            default: begin
              w_next = S_DONE;
              w_dat  = r_we ? 64'd0 : resp.dat;
            end
          endcase
        end
`ifdef WB_INIT_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_next   = S_DONE;
          w_status = INIT_TIMEOUT;
        end
`endif
      end
      S_BACKOFF: if (r_backoff == c_backoff_last) w_next = S_ISSUE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Command latch, tid/retry/back-off counters and completion result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_posted     <= 1'b0;
      r_adr        <= '0;
      r_sel        <= '0;
      r_dat        <= '0;
      r_tid        <= '0;
      r_retry      <= '0;
      r_backoff    <= '0;
      r_rsp_status <= '0;
      r_rsp_dat    <= '0;
    end else begin
      if (w_accept) begin
        r_we     <= cmd_we;
        r_posted <= cmd_posted;
        r_adr    <= cmd_adr;
        r_sel    <= cmd_sel;
        r_dat    <= cmd_dat;
        r_tid    <= r_tid + WB_TID_W'(1);
        r_retry  <= '0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + 8'd1;
      end
      r_backoff <= (r_state == S_BACKOFF) ? r_backoff + 2'd1 : 2'd0;
      if ((r_state != S_DONE) && (w_next == S_DONE)) begin
        r_rsp_status <= w_status;
        r_rsp_dat    <= w_dat;
      end
    end
  end

  // Bus request: fields follow the latched command, strobes only while the cycle is open.
  always_comb begin
    req     = '0;
    req.cyc = w_bus_active;
    req.stb = w_bus_active;
    req.we  = r_we;
    req.adr = r_adr;
    req.sel = r_sel;
    req.dat = r_dat;
    req.tid = r_tid;
    req.cti = (r_we && !r_posted) ? WB_CTI_ERC : WB_CTI_CLASSIC;
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_DONE);
  assign rsp_status = r_rsp_status;
  assign rsp_dat    = r_rsp_dat;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_initiator64.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_cmd_initiator64
// Description : Self-checking bench for wb_cmd_initiator64. Scripted
//               responder, directed vector table, randomized commands checked
//               against a cycle-count/outcome model, reset-abort sequence.
//               Timeout vectors are included when WB_INIT_TIMEOUT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_cmd_initiator64;
  import wishbone_pkg::*;

`ifdef WB_INIT_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1023;
`endif
  localparam int MAXR = 3;

  // Final response kinds given by the responder after its rty responses.
  localparam int FIN_ACK    = 0;
  localparam int FIN_ERR    = 1;
  localparam int FIN_ACKERR = 2;
  localparam int FIN_SILENT = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_we;
  logic               cmd_posted;
  logic [31:0]        cmd_adr;
  logic [7:0]         cmd_sel;
  logic [63:0]        cmd_dat;
  wb_cmd_request64_t  req;
  wb_cmd_response64_t resp;
  logic               rsp_valid;
  logic [1:0]         rsp_status;
  logic [63:0]        rsp_dat;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [3:0] m_tid  = 4'd0;

  typedef struct {
    logic        we;
    logic        posted;
    logic [31:0] adr;
    logic [7:0]  sel;
    logic [63:0] dat;
    logic [63:0] rdat;
    int          n_rty;
    int          fin;
    int          delay;
    bit          junk;
    logic [1:0]  exp_status;
  } vec_t;

  vec_t tbl[$];

`ifdef WB_INIT_TIMEOUT_EN
  wb_cmd_initiator64 #(.TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (
`else
  wb_cmd_initiator64 #(.MAX_RETRY(MAXR)) dut (
`endif
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_posted(cmd_posted),
    .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
    .req(req), .resp(resp),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_dat(rsp_dat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic we, input logic posted, input logic [31:0] adr,
                              input logic [63:0] dat, input logic [63:0] rdat, input int n_rty,
                              input int fin, input int delay, input bit junk, input logic [1:0] st);
    vec_t v;
    v.we = we; v.posted = posted; v.adr = adr; v.sel = 8'hFF; v.dat = dat; v.rdat = rdat;
    v.n_rty = n_rty; v.fin = fin; v.delay = delay; v.junk = junk; v.exp_status = st;
    return v;
  endfunction

  // Outcome model: posted writes always succeed; otherwise more than MAXR rty
  // responses exhaust the retries, else the final response decides.
  function automatic logic [1:0] model_status(input vec_t v);
    if (v.we && v.posted) return 2'd0;
    if (v.n_rty > MAXR)   return 2'd3;
    case (v.fin)
      FIN_ACK:    return 2'd0;
      FIN_SILENT: return 2'd2;
      default:    return 2'd1;
    endcase
  endfunction

  // Issue one command, play the responder script and check the whole exchange.
  task automatic run_vec(input vec_t v, input logic [1:0] exp_st);
    int         t, s, k, n_iss, n_iss_exp, period, exp_done, last_wait;
    bit         done, prev_cyc, last, posted_wr;
    logic [3:0] tid_exp;
    wb_cti_t    cti_exp;
    posted_wr = v.we && v.posted;
    cti_exp   = (v.we && !v.posted) ? WB_CTI_ERC : WB_CTI_CLASSIC;
    chk("cmd_ready_idle", 128'(cmd_ready), 128'(1'b1));
    cmd_valid = 1'b1; cmd_we = v.we; cmd_posted = v.posted;
    cmd_adr = v.adr; cmd_sel = v.sel; cmd_dat = v.dat;
    m_tid   = m_tid + 4'd1;
    tid_exp = m_tid;
    n_iss_exp = posted_wr ? 1 : ((v.n_rty > MAXR) ? MAXR + 1 : v.n_rty + 1);
    period    = 1 + v.delay + 4;
    last_wait = (!posted_wr && v.n_rty <= MAXR && v.fin == FIN_SILENT) ? TMO : v.delay;
    exp_done  = posted_wr ? 2 : 1 + (n_iss_exp - 1) * period + last_wait + 1;
    tick();
    cmd_valid = 1'b0; cmd_adr = ~v.adr; cmd_sel = ~v.sel; cmd_dat = ~v.dat; cmd_we = ~v.we;
    t = 1; s = 0; n_iss = 0; done = 1'b0; prev_cyc = 1'b0;
    while (!done && t < 400) begin
      if (req.cyc && !prev_cyc) begin
        n_iss++;
        s = t;
        chk("issue_start", 128'(t), 128'(1 + (n_iss - 1) * period));
      end
      if (req.cyc) begin
        chk("req_fields", 128'({req.stb, req.we, req.adr, req.sel, req.dat, req.tid, req.cti}),
            128'({1'b1, v.we, v.adr, v.sel, v.dat, tid_exp, cti_exp}));
      end
      resp = '0;
      if (req.cyc && t > s && !posted_wr) begin
        k    = t - s;
        last = (n_iss > v.n_rty);
        if (k == v.delay && !(last && v.fin == FIN_SILENT)) begin
          resp.tid = tid_exp;
          if (!last) resp.rty = 1'b1;
          else begin
            resp.ack = (v.fin == FIN_ACK) || (v.fin == FIN_ACKERR);
            resp.err = (v.fin == FIN_ERR) || (v.fin == FIN_ACKERR);
            resp.dat = v.rdat;
          end
        end else if (v.junk) begin
          resp.tid = tid_exp ^ 4'h8;
          case ($urandom_range(0, 2))
            0:       resp.ack = 1'b1;
            1:       resp.err = 1'b1;
            default: resp.rty = 1'b1;
          endcase
          resp.dat = {$urandom, $urandom};
        end
      end
      if (rsp_valid) begin
        done = 1'b1;
        chk("done_cycle", 128'(t), 128'(exp_done));
        chk("status", 128'(rsp_status), 128'(exp_st));
        if (exp_st == 2'd0) chk("rsp_dat", 128'(rsp_dat), v.we ? 128'(0) : 128'(v.rdat));
        chk("issue_count", 128'(n_iss), 128'(n_iss_exp));
        chk("cyc_in_done", 128'({req.cyc, req.stb}), 128'(2'b00));
        chk("cmd_ready_done", 128'(cmd_ready), 128'(1'b0));
      end
      prev_cyc = req.cyc;
      tick();
      t++;
    end
    resp = '0;
    chk("rsp_valid_seen", 128'(done), 128'(1'b1));
    chk("rsp_valid_one_cycle", 128'(rsp_valid), 128'(1'b0));
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_posted = 1'b0;
    cmd_adr = '0; cmd_sel = '0; cmd_dat = '0; resp = '0;
    repeat (3) tick();
    chk("rst_req", 128'(req), 128'(0));
    chk("rst_rsp", 128'({rsp_valid, rsp_status, rsp_dat}), 128'(0));
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1'b1));
    rst = 1'b0;
    tick();

    tbl.push_back(mk(1'b0, 1'b0, 32'h0000_1000, 64'h0, 64'h1122334455667788, 0, FIN_ACK, 1, 1'b0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0000_2000, 64'hA5, 64'hDEAD_BEEF, 0, FIN_ACK, 1, 1'b0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 32'h0000_3000, 64'h5A5A, 64'h0, 0, FIN_ACK, 1, 1'b0, 2'd0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0000_4000, 64'h0, 64'h77, 4, FIN_ACK, 1, 1'b0, 2'd3));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0000_5000, 64'h0, 64'hCAFE_F00D_1234_5678, 2, FIN_ACK, 1, 1'b0, 2'd0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0000_6000, 64'h0, 64'h99, 0, FIN_ACKERR, 2, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0000_7000, 64'h1234, 64'h0, 0, FIN_ERR, 3, 1'b1, 2'd1));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0000_8000, 64'h0, 64'h0BAD_C0DE_0000_0001, 0, FIN_ACK, 5, 1'b1, 2'd0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0000_9000, 64'h0, 64'h0123_4567_89AB_CDEF, 3, FIN_ACK, 2, 1'b1, 2'd0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0000_A000, 64'h0, 64'hFEDC_BA98_7654_3210, 0, FIN_ACK, 1, 1'b0, 2'd0));
`ifdef WB_INIT_TIMEOUT_EN
    tbl.push_back(mk(1'b0, 1'b0, 32'h0000_B000, 64'h0, 64'h0, 0, FIN_SILENT, 1, 1'b1, 2'd2));
    tbl.push_back(mk(1'b1, 1'b0, 32'h0000_C000, 64'h42, 64'h0, 1, FIN_SILENT, 2, 1'b0, 2'd2));
`endif
    foreach (tbl[i]) run_vec(tbl[i], tbl[i].exp_status);

    for (int i = 0; i < 40; i++) begin
      v.we     = 1'($urandom_range(0, 1));
      v.posted = 1'($urandom_range(0, 1));
      v.adr    = $urandom;
      v.sel    = 8'($urandom);
      v.dat    = {$urandom, $urandom};
      v.rdat   = {$urandom, $urandom};
      v.n_rty  = $urandom_range(0, 5);
`ifdef WB_INIT_TIMEOUT_EN
      v.fin    = ($urandom_range(0, 7) == 0) ? FIN_SILENT : $urandom_range(0, 2);
`else
      v.fin    = $urandom_range(0, 2);
`endif
      v.delay  = $urandom_range(1, 4);
      v.junk   = 1'($urandom_range(0, 1));
      run_vec(v, model_status(v));
    end

    // Reset while waiting on a response that never comes.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_posted = 1'b0; cmd_adr = 32'h0000_D000;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("cyc_before_rst", 128'(req.cyc), 128'(1'b1));
    rst = 1'b1;
    tick();
    chk("cyc_after_rst", 128'({req.cyc, req.stb}), 128'(2'b00));
    chk("req_zero_after_rst", 128'(req), 128'(0));
    chk("rsp_valid_in_rst", 128'(rsp_valid), 128'(1'b0));
    rst   = 1'b0;
    m_tid = 4'd0;
    tick();
    chk("cmd_ready_after_rst", 128'(cmd_ready), 128'(1'b1));
    for (int i = 0; i < 3; i++) begin
      chk("no_rsp_after_abort", 128'(rsp_valid), 128'(1'b0));
      tick();
    end
    run_vec(mk(1'b0, 1'b0, 32'h0000_E000, 64'h0, 64'h5555_AAAA_5555_AAAA, 0, FIN_ACK, 1, 1'b0, 2'd0), 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
